// File: rtl/game_pkg.sv
// game_pkg: shared state and screen-kind encodings plus default durations for screen_scheduler
package game_pkg;
    typedef enum logic [2:0] {IDLE, TITLE, TRACE, MESSAGE, SCORE, RESTART} state_t;
    localparam logic [1:0] KIND_TITLE = 2'd0;
    localparam logic [1:0] KIND_TRACE = 2'd1;
    localparam logic [1:0] KIND_MSG = 2'd2;
    localparam logic [1:0] KIND_SCORE = 2'd3;
    localparam int DEF_CYC_PER_SEC = 50000000;
    localparam int DEF_TITLE_SEC = 3;
    localparam int DEF_TRACE_SEC = 10;
    localparam int DEF_MSG_SEC = 5;
    localparam int DEF_SCORE_SEC = 4;
    localparam int DEF_PU_START_SEC = 2;
    localparam int DEF_PU_END_SEC = 6;
    localparam int DEF_PU_THRESH = 64;
    function automatic logic [1:0] kind_of(state_t s);
        return s == TRACE ? KIND_TRACE : s == MESSAGE ? KIND_MSG : (s == SCORE || s == RESTART) ? KIND_SCORE : KIND_TITLE;
    endfunction
endpackage

// File: rtl/screen_scheduler_if.sv
// screen_scheduler_if: control inputs and status outputs of screen_scheduler
interface screen_scheduler_if;
    logic        start;
    logic        pause;
    logic        skip;
    logic [5:0]  total_screens;
    logic [31:0] random;
    logic [4:0]  curr_screen;
    logic [1:0]  screen_kind;
    logic [31:0] time_out;
    logic        end_of_game;
    logic        snitch_powerup;
    logic        play_again;
    logic        busy;
    modport master (
        output start, pause, skip, total_screens, random,
        input  curr_screen, screen_kind, time_out, end_of_game, snitch_powerup, play_again, busy
    );
    modport slave (
        input  start, pause, skip, total_screens, random,
        output curr_screen, screen_kind, time_out, end_of_game, snitch_powerup, play_again, busy
    );
endinterface

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: prescaler producing a one-cycle tick every CYC_PER_SEC unheld cycles
module sec_tick_gen #(
    parameter int CYC_PER_SEC = 50000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_hold,
    input  logic i_clr,
    output logic o_tick
);
    logic [31:0] r_cnt;
    assign o_tick = !i_hold && !i_clr && r_cnt == 32'(CYC_PER_SEC - 1);
    // Count unheld cycles and wrap once per second; clearing restarts the phase at zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (!i_hold) r_cnt <= o_tick ? '0 : r_cnt + 32'd1;
    end
endmodule

// File: rtl/screen_scheduler.sv
// screen_scheduler: sequences title, alternating trace/message screens, scoreboard and restart
// Optional snitch powerup window is built when SCREEN_SCHED_POWERUP_EN is defined.
module screen_scheduler
    import game_pkg::*;
#(
    parameter int CYC_PER_SEC  = DEF_CYC_PER_SEC,
    parameter int TITLE_SEC    = DEF_TITLE_SEC,
    parameter int TRACE_SEC    = DEF_TRACE_SEC,
    parameter int MSG_SEC      = DEF_MSG_SEC,
    parameter int SCORE_SEC    = DEF_SCORE_SEC,
    parameter int PU_START_SEC = DEF_PU_START_SEC,
    parameter int PU_END_SEC   = DEF_PU_END_SEC,
    parameter int PU_THRESH    = DEF_PU_THRESH
) (
    input  logic              clock,
    input  logic              reset_n,
    screen_scheduler_if.slave bus
);
    state_t      r_state;
    logic [31:0] r_sec;
    logic [31:0] r_time;
    logic [4:0]  r_screen;
    logic [1:0]  r_kind;
    logic        r_eog;
    logic        r_again;
    logic        r_busy;
    logic        w_tick;
    logic        w_clr;
    logic        w_expire;
    logic        w_skip;
    logic        w_adv;
    logic        w_title;
    logic [4:0]  w_total;
    logic [4:0]  w_nscreen;
    state_t      w_adv_state;
    state_t      w_next;

    function automatic logic [31:0] dur_of(state_t s);
        return s == TITLE ? 32'(TITLE_SEC) : s == TRACE ? 32'(TRACE_SEC) : s == MESSAGE ? 32'(MSG_SEC) : 32'(SCORE_SEC);
    endfunction

    assign w_clr = r_state == IDLE || r_state == RESTART;

    sec_tick_gen #(.CYC_PER_SEC(CYC_PER_SEC)) u_sec_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .i_hold (bus.pause),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Next state: expiry and skip together still advance exactly one screen; the clamped total marks the scoreboard
    always_comb begin
        w_total     = bus.total_screens < 6'd2 ? 5'd2 : bus.total_screens > 6'd31 ? 5'd31 : bus.total_screens[4:0];
        w_expire    = w_tick && r_sec == dur_of(r_state) - 32'd1;
        w_skip      = bus.skip && !bus.pause && (r_state == TRACE || r_state == MESSAGE);
        w_adv       = (r_state == TITLE || r_state == TRACE || r_state == MESSAGE) && (w_expire || w_skip);
        w_title     = (r_state == IDLE && bus.start) || r_state == RESTART;
        w_adv_state = r_screen + 5'd1 >= w_total ? SCORE : r_screen[0] ? TRACE : MESSAGE;
        w_next      = w_title ? TITLE : w_adv ? w_adv_state : (r_state == SCORE && w_expire) ? RESTART : r_state;
        w_nscreen   = w_title ? 5'd1 : w_adv ? r_screen + 5'd1 : r_screen;
    end

    // Screen FSM with registered outputs derived from the state being entered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_sec    <= '0;
            r_time   <= '0;
            r_screen <= '0;
            r_kind   <= KIND_TITLE;
            r_eog    <= 1'b0;
            r_again  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_sec    <= w_next != r_state ? '0 : r_sec + {31'd0, w_tick};
            r_time   <= w_title ? '0 : r_time + {31'd0, w_tick};
            r_screen <= w_nscreen;
            r_kind   <= kind_of(w_next);
            r_eog    <= w_next == SCORE;
            r_again  <= w_next == RESTART;
            r_busy   <= w_next != IDLE;
        end
    end

    assign bus.curr_screen = r_screen;
    assign bus.screen_kind = r_kind;
    assign bus.time_out    = r_time;
    assign bus.end_of_game = r_eog;
    assign bus.play_again  = r_again;
    assign bus.busy        = r_busy;

`ifdef SCREEN_SCHED_POWERUP_EN
    logic [7:0] r_rand;
    // Capture the powerup odds draw as each trace screen begins
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_rand <= '0;
        else if (w_next == TRACE && r_state != TRACE) r_rand <= bus.random[7:0];
    end
    assign bus.snitch_powerup = r_state == TRACE && r_sec >= 32'(PU_START_SEC) && r_sec < 32'(PU_END_SEC) && {24'd0, r_rand} < 32'(PU_THRESH);
`else
    assign bus.snitch_powerup = 1'b0;
`endif
endmodule

// File: doc/screen_scheduler.md
SCREEN_SCHEDULER -- requirements
Module: screen_scheduler

Interface
REQ-001 SHALL have parameter CYC_PER_SEC, default 50000000, clock cycles per game second.
REQ-002 SHALL have parameter TITLE_SEC, default 3, title screen duration in seconds.
REQ-003 SHALL have parameter TRACE_SEC, default 10, even (trace) screen duration in seconds.
REQ-004 SHALL have parameter MSG_SEC, default 5, odd (message) screen duration in seconds.
REQ-005 SHALL have parameter SCORE_SEC, default 4, scoreboard hold time before restart.
REQ-006 SHALL have parameters PU_START_SEC=2, PU_END_SEC=6 and PU_THRESH=64, defining the snitch powerup window and odds.
REQ-007 SHALL have port clock, input, 1, single system clock (rising edge).
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, level-sensitive game start request.
REQ-010 SHALL have port pause, input, 1, freezes all timing while high.
REQ-011 SHALL have port skip, input, 1, single-cycle pulse that ends the current trace/message screen early.
REQ-012 SHALL have port total_screens, input, 6, index of the final (scoreboard) screen.
REQ-013 SHALL have port random, input, 32, free-running random word.
REQ-014 SHALL have outputs curr_screen [4:0], screen_kind [1:0] (0 title, 1 trace, 2 message, 3 score), time_out [31:0] (game seconds), end_of_game, snitch_powerup, play_again, busy.

Function
REQ-015 SHALL implement states IDLE, TITLE, TRACE, MESSAGE, SCORE, RESTART.
REQ-016 SHALL derive a one-cycle sec_tick every CYC_PER_SEC unpaused cycles; the prescaler and tick are held while pause=1.
REQ-017 SHALL move IDLE->TITLE on start=1 with curr_screen=1, time_out=0 and screen second counter=0.
REQ-018 SHALL expire a screen on the sec_tick at which the screen second counter equals duration-1; the state and curr_screen update on the next clock edge.
REQ-019 SHALL advance on expiry or skip to curr_screen+1: even index -> TRACE, odd -> MESSAGE, equal to the effective total -> SCORE.
REQ-020 SHALL clamp the effective total to the range 2..31 (values 0/1 -> 2; values 32..63 -> 31).
REQ-021 SHALL treat skip coinciding with expiry as a single advance; skip SHALL be ignored in IDLE, TITLE, SCORE and RESTART, and while pause=1.
REQ-022 SHALL hold end_of_game=1 exactly while in SCORE.
REQ-023 SHALL move SCORE->RESTART on expiry; RESTART SHALL last one cycle, pulse play_again=1 and go to TITLE with curr_screen=1 and time_out=0.
REQ-024 SHALL increment time_out on each sec_tick outside IDLE, wrapping modulo 2^32.
REQ-025 SHALL hold busy=1 in every state except IDLE; start SHALL be ignored outside IDLE.

Reset
REQ-026 SHALL, while reset_n=0, force state IDLE, curr_screen=0, screen_kind=0, time_out=0, all counters 0, and end_of_game, snitch_powerup, play_again and busy to 0; mid-game reset aborts immediately.

Configuration
REQ-027 SHALL, with macro SCREEN_SCHED_POWERUP_EN defined, latch random[7:0] on TRACE entry and assert snitch_powerup while in TRACE, PU_START_SEC <= screen seconds < PU_END_SEC, and latched value < PU_THRESH; snitch_powerup SHALL drop on the edge that leaves TRACE.
REQ-028 SHALL, without SCREEN_SCHED_POWERUP_EN, tie snitch_powerup to 0 and omit the latch.

Structure
REQ-029 SHALL place the state enum, screen_kind encodings and duration defaults in shared package game_pkg.
REQ-030 SHALL instantiate one sub-module, sec_tick_gen (prescaler with hold input), producing sec_tick.

Verification (CYC_PER_SEC=4)
REQ-031 SHALL check: reset, start=1 at total_screens=5 -> title for 12 cycles, then screens 2,3,4 with kinds 1,2,1 at 40/20/40 cycles, then SCORE with end_of_game=1.
REQ-032 SHALL check: SCORE held 16 cycles -> play_again high for exactly 1 cycle, curr_screen=1, time_out=0.
REQ-033 SHALL check: skip in screen 2 at second 1 -> curr_screen=3 on the next edge; skip together with expiry -> advance by exactly 1.
REQ-034 SHALL check: pause for 100 cycles mid-trace -> time_out and curr_screen unchanged; timing resumes with the prescaler phase preserved.
REQ-035 SHALL check with POWERUP_EN: random[7:0]=10 -> snitch_powerup high for seconds 2..5 of the trace; random[7:0]=200 -> snitch_powerup never high.
REQ-036 SHALL check: total_screens=0 -> TITLE then SCORE directly; reset_n low mid-trace -> all outputs 0 asynchronously.
